// File: rtl/paddle_ctrl_if.sv
// Bundle of the paddle controller's keypad-side inputs, frame tick and
// paddle/key outputs. The slave modport is the controller's view; the
// master modport is the view of whatever drives the keypad and frame tick.
interface paddle_ctrl_if;
    logic [3:0] keycode;
    logic       key_pressed;
    logic       frame_tick;
    logic [9:0] paddle_y;
    logic       key_valid;
    logic [3:0] key_db;
    logic       press_pulse;

    modport master (
        output keycode,
        output key_pressed,
        output frame_tick,
        input  paddle_y,
        input  key_valid,
        input  key_db,
        input  press_pulse
    );

    modport slave (
        input  keycode,
        input  key_pressed,
        input  frame_tick,
        output paddle_y,
        output key_valid,
        output key_db,
        output press_pulse
    );
endinterface

// File: rtl/paddle_ctrl.sv
// Per-player paddle controller: debounces the keypad scanner's key, emits a
// one-cycle press pulse on commit, and once per frame moves the paddle up or
// down, clamped to the playfield. Committing the centre key recentres it.
module paddle_ctrl #(
    parameter int         SCREEN_H        = 480,
    parameter int         PADDLE_H        = 64,
    parameter int         SPEED           = 4,
    parameter int         DEBOUNCE_CYCLES = 250000,
    parameter logic [3:0] KEY_UP          = 4'h2,
    parameter logic [3:0] KEY_DOWN        = 4'h8,
    parameter logic [3:0] KEY_CENTER      = 4'h5
) (
    input  logic          clk,
    input  logic          rst_n,
    paddle_ctrl_if.slave  bus
);

    localparam int MAX_Y    = SCREEN_H - PADDLE_H;
    localparam int CENTER_Y = MAX_Y / 2;
    localparam int CW       = $clog2(DEBOUNCE_CYCLES);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [10:0]   MAX_Y11   = 11'(MAX_Y);
    localparam logic [10:0]   SPEED11   = 11'(SPEED);
    localparam logic [9:0]    SPEED10   = 10'(SPEED);
    localparam logic [9:0]    MAX_Y10   = 10'(MAX_Y);
    localparam logic [9:0]    CENTER10  = 10'(CENTER_Y);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ARMING    = 2'd1;
    localparam logic [1:0] S_HELD      = 2'd2;
    localparam logic [1:0] S_RELEASING = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_cand;
    logic [3:0]    r_key_db;
    logic          r_key_valid;
    logic          r_press_pulse;
    logic [9:0]    r_paddle_y;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    w_cand_nxt;
    logic          w_commit;
    logic          w_release;
    logic          w_match_cand;
    logic          w_match_held;
    logic [10:0]   w_y11;
    logic [10:0]   w_down_sum;
    logic [9:0]    w_y_up;
    logic [9:0]    w_y_down;
    logic [9:0]    w_y_nxt;

    assign w_match_cand = bus.key_pressed && (bus.keycode == r_cand);
    assign w_match_held = bus.key_pressed && (bus.keycode == r_key_db);

    // Debounce FSM next-state: candidate arming, hold, and release windows share one counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_commit    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.key_pressed) begin
                    w_cand_nxt  = bus.keycode;
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = S_ARMING;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ARMING: begin
                if (w_match_cand) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = S_HELD;
                        w_cnt_nxt   = CNT_ZERO;
                        w_commit    = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end else if (bus.key_pressed) begin
                    // A different key restarts the stability window on the new code.
                    w_cand_nxt = bus.keycode;
                    w_cnt_nxt  = CNT_ZERO;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            S_HELD: begin
                w_cnt_nxt = CNT_ZERO;
                if (w_match_held) begin
                    w_state_nxt = S_HELD;
                end else begin
                    w_state_nxt = S_RELEASING;
                end
            end
            S_RELEASING: begin
                // Any non-matching input, including another key, counts toward release.
                if (w_match_held) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                    w_release   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Paddle next position: recentre on centre-key commit, else clamped motion on frame tick.
    always_comb begin
        w_y11      = {1'b0, r_paddle_y};
        w_down_sum = w_y11 + SPEED11;
        w_y_up     = (w_y11 < SPEED11) ? 10'd0 : (r_paddle_y - SPEED10);
        w_y_down   = (w_down_sum > MAX_Y11) ? MAX_Y10 : w_down_sum[9:0];
        w_y_nxt    = r_paddle_y;
        if (w_commit && (r_cand == KEY_CENTER)) begin
            w_y_nxt = CENTER10;
        end else if (bus.frame_tick && r_key_valid) begin
            if (r_key_db == KEY_UP) begin
                w_y_nxt = w_y_up;
            end else if (r_key_db == KEY_DOWN) begin
                w_y_nxt = w_y_down;
            end else begin
                w_y_nxt = r_paddle_y;
            end
        end else begin
            w_y_nxt = r_paddle_y;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= CNT_ZERO;
            r_cand        <= 4'd0;
            r_key_db      <= 4'd0;
            r_key_valid   <= 1'b0;
            r_press_pulse <= 1'b0;
            r_paddle_y    <= CENTER10;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_cand        <= w_cand_nxt;
            r_press_pulse <= w_commit;
            r_paddle_y    <= w_y_nxt;
            if (w_commit) begin
                r_key_db    <= r_cand;
                r_key_valid <= 1'b1;
            end else if (w_release) begin
                r_key_db    <= 4'd0;
                r_key_valid <= 1'b0;
            end else begin
                r_key_db    <= r_key_db;
                r_key_valid <= r_key_valid;
            end
        end
    end

    assign bus.paddle_y    = r_paddle_y;
    assign bus.key_valid   = r_key_valid;
    assign bus.key_db      = r_key_db;
    assign bus.press_pulse = r_press_pulse;

endmodule
